// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch PC logic.
//   PC_WIDTH    : width of every program counter (64)
//   INSTR_BYTES : fetch stride in bytes (4)
//   TAG_WIDTH   : BTB tag width, PC bits 63:2
//   btb_entry_t : one branch-target-buffer entry (valid, tag, target)
//   pc_inc()    : sequential PC step, wraps modulo 2^PC_WIDTH
// -----------------------------------------------------------------------------
package fetch_pkg;

   localparam int PC_WIDTH    = 64;
   localparam int INSTR_BYTES = 4;
   localparam int TAG_WIDTH   = PC_WIDTH - 2;

   typedef struct packed {
      logic                 valid;
      logic [TAG_WIDTH-1:0] tag;
      logic [PC_WIDTH-1:0]  target;
   } btb_entry_t;

   // Plain unsigned add; the carry out of bit 63 is dropped so the top of the
   // address space wraps to 0.
   function automatic logic [PC_WIDTH-1:0] pc_inc(input logic [PC_WIDTH-1:0] pc);
      return pc + PC_WIDTH'(INSTR_BYTES);
   endfunction

endpackage

// File: rtl/fetch_pc_unit_btb_cam.sv
// -----------------------------------------------------------------------------
// btb_cam
// Fully-associative branch target buffer with FIFO replacement.
// Ports:
//   clk, resetl    : clock, asynchronous active-low reset (clears all valids,
//                    replacement pointer back to 0)
//   lookup_tag     : PC[63:2] being fetched (combinational lookup)
//   lookup_hit     : exactly one valid entry matches lookup_tag
//   lookup_target  : stored target of the matching entry (0 on no match)
//   upd_en         : a taken branch resolves this cycle
//   upd_tag        : PC[63:2] of the resolving branch
//   upd_target     : its actual target
// Lookup sees the contents before this cycle's update (no write bypass).
// -----------------------------------------------------------------------------
module btb_cam
   import fetch_pkg::*;
#(
   parameter int BTB_ENTRIES = 4
) (
   input  logic                 clk,
   input  logic                 resetl,
   input  logic [TAG_WIDTH-1:0] lookup_tag,
   output logic                 lookup_hit,
   output logic [PC_WIDTH-1:0]  lookup_target,
   input  logic                 upd_en,
   input  logic [TAG_WIDTH-1:0] upd_tag,
   input  logic [PC_WIDTH-1:0]  upd_target
);

   localparam int PTR_W = $clog2(BTB_ENTRIES);

   btb_entry_t             entry_reg [BTB_ENTRIES];
   logic [PTR_W-1:0]       ptr_reg;
   logic [PTR_W-1:0]       ptr_next;
   logic [BTB_ENTRIES-1:0] lookup_match;
   logic [BTB_ENTRIES-1:0] upd_match;
   logic [BTB_ENTRIES-1:0] wr_en;
   logic                   upd_hit;

   assign upd_hit = |upd_match;

   // A known branch only has its target refreshed; an unknown one takes the
   // slot under the FIFO pointer.
   generate
      for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_entry
         assign lookup_match[gi] = entry_reg[gi].valid && (entry_reg[gi].tag == lookup_tag);
         assign upd_match[gi]    = entry_reg[gi].valid && (entry_reg[gi].tag == upd_tag);
         assign wr_en[gi]        = upd_en && (upd_hit ? upd_match[gi]
                                                      : (ptr_reg == PTR_W'(gi)));
      end
   endgenerate

   // One-hot test: non-zero and clearing the lowest set bit leaves nothing.
   assign lookup_hit = (lookup_match != '0) &&
                       ((lookup_match & (lookup_match - BTB_ENTRIES'(1))) == '0);

   always_comb begin
      lookup_target = '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
         if (lookup_match[i]) begin
            lookup_target = lookup_target | entry_reg[i].target;
         end
      end
   end

   // Power-of-two depth, so the natural counter overflow is the modulo wrap.
   assign ptr_next = (upd_en && !upd_hit) ? ptr_reg + PTR_W'(1) : ptr_reg;

   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            entry_reg[i] <= '0;
         end
         ptr_reg <= '0;
      end else begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            if (wr_en[i]) begin
               entry_reg[i] <= '{valid: 1'b1, tag: upd_tag, target: upd_target};
            end
         end
         ptr_reg <= ptr_next;
      end
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
// Fetch program counter with MEM-stage redirect and optional BTB prediction.
// Build option: define FETCH_BTB_EN to include the branch target buffer
// (btb_cam). Without it there is no BTB storage and no predicted redirect.
// Parameters:
//   RESET_PC    : PC loaded while resetl is low
//   BTB_ENTRIES : BTB depth, power of two in 2..16
// Ports:
//   clk                : clock, all state on rising edge
//   resetl             : asynchronous active-low reset
//   stall_IF           : hold the PC
//   branch_predict     : taken prediction for pc_IF
//   mem_branch_valid   : a branch resolves in MEM this cycle
//   pc_MEM             : PC of that branch
//   branch_taken_MEM   : its actual outcome
//   branch_target_MEM  : its actual taken target
//   mispredict_MEM     : the earlier prediction was wrong
//   pc_IF              : registered fetch PC
//   predicted_taken_IF : fetch follows a BTB target this cycle
//   flush              : squash IF/ID, ID/EX and EX/MEM
// -----------------------------------------------------------------------------
module fetch_pc_unit
   import fetch_pkg::*;
#(
   parameter logic [63:0] RESET_PC    = 64'h0,
   parameter int          BTB_ENTRIES = 4
) (
   input  logic        clk,
   input  logic        resetl,
   input  logic        stall_IF,
   input  logic        branch_predict,
   input  logic        mem_branch_valid,
   input  logic [63:0] pc_MEM,
   input  logic        branch_taken_MEM,
   input  logic [63:0] branch_target_MEM,
   input  logic        mispredict_MEM,
   output logic [63:0] pc_IF,
   output logic        predicted_taken_IF,
   output logic        flush
);

   generate
      if ((BTB_ENTRIES < 2) || (BTB_ENTRIES > 16) ||
          ((BTB_ENTRIES & (BTB_ENTRIES - 1)) != 0)) begin : g_bad_btb_entries
         $error("fetch_pc_unit: BTB_ENTRIES must be a power of two in 2..16");
      end
   endgenerate

   logic [PC_WIDTH-1:0] pc_reg;
   logic [PC_WIDTH-1:0] pc_next;
   logic [PC_WIDTH-1:0] redirect_pc;
   logic [PC_WIDTH-1:0] btb_target;
   logic                btb_hit;
   logic                redirect;

   // Qualified by resetl so flush stays low while reset is held, whatever the
   // MEM-stage inputs happen to be.
   assign redirect    = mem_branch_valid & mispredict_MEM & resetl;
   assign redirect_pc = branch_taken_MEM ? branch_target_MEM : pc_inc(pc_MEM);

`ifdef FETCH_BTB_EN
   btb_cam #(
      .BTB_ENTRIES (BTB_ENTRIES)
   ) u_btb_cam (
      .clk           (clk),
      .resetl        (resetl),
      .lookup_tag    (pc_reg[PC_WIDTH-1:2]),
      .lookup_hit    (btb_hit),
      .lookup_target (btb_target),
      .upd_en        (mem_branch_valid & branch_taken_MEM),
      .upd_tag       (pc_MEM[PC_WIDTH-1:2]),
      .upd_target    (branch_target_MEM)
   );
`else
   assign btb_hit    = 1'b0;
   assign btb_target = '0;
`endif

   assign predicted_taken_IF = btb_hit & branch_predict & ~stall_IF & ~redirect;
   assign flush              = redirect;

   always_comb begin
      pc_next = pc_inc(pc_reg);
      if (redirect) begin
         pc_next = redirect_pc;
      end else if (stall_IF) begin
         pc_next = pc_reg;
      end else if (predicted_taken_IF) begin
         pc_next = btb_target;
      end
   end

   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         pc_reg <= RESET_PC;
      end else begin
         pc_reg <= pc_next;
      end
   end

   assign pc_IF = pc_reg;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_unit
// Directed bench for fetch_pc_unit (RESET_PC = 64'h1000, BTB_ENTRIES = 4).
// Expectations follow the build: with FETCH_BTB_EN the BTB predicts, without
// it every lookup misses.
// -----------------------------------------------------------------------------
module tb_fetch_pc_unit;

`ifdef FETCH_BTB_EN
   localparam bit BTB_ON = 1'b1;
`else
   localparam bit BTB_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        resetl;
   logic        stall_IF;
   logic        branch_predict;
   logic        mem_branch_valid;
   logic [63:0] pc_MEM;
   logic        branch_taken_MEM;
   logic [63:0] branch_target_MEM;
   logic        mispredict_MEM;
   logic [63:0] pc_IF;
   logic        predicted_taken_IF;
   logic        flush;

   int test_cnt = 0;
   int fail_cnt = 0;

   fetch_pc_unit #(
      .RESET_PC    (64'h1000),
      .BTB_ENTRIES (4)
   ) dut (
      .clk                (clk),
      .resetl             (resetl),
      .stall_IF           (stall_IF),
      .branch_predict     (branch_predict),
      .mem_branch_valid   (mem_branch_valid),
      .pc_MEM             (pc_MEM),
      .branch_taken_MEM   (branch_taken_MEM),
      .branch_target_MEM  (branch_target_MEM),
      .mispredict_MEM     (mispredict_MEM),
      .pc_IF              (pc_IF),
      .predicted_taken_IF (predicted_taken_IF),
      .flush              (flush)
   );

   always #5 clk = ~clk;

   task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      test_cnt++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      test_cnt++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic idle();
      stall_IF          = 1'b0;
      branch_predict    = 1'b0;
      mem_branch_valid  = 1'b0;
      pc_MEM            = '0;
      branch_taken_MEM  = 1'b0;
      branch_target_MEM = '0;
      mispredict_MEM    = 1'b0;
   endtask

   // Advance one cycle and land on the falling edge for the next step.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Steer fetch to x with a not-taken redirect (leaves the BTB alone), then
   // predict taken at x and check whether the BTB supplies a target.
   task automatic probe(input logic [63:0] x, input bit exp_hit, input logic [63:0] exp_tgt);
      logic [63:0] exp_next;
      idle();
      mem_branch_valid = 1'b1;
      mispredict_MEM   = 1'b1;
      pc_MEM           = x - 64'd4;
      #1;
      chk1("probe_flush", flush, 1'b1);
      tick();
      idle();
      chk64("probe_pc", pc_IF, x);
      branch_predict = 1'b1;
      #1;
      chk1("probe_pred", predicted_taken_IF, exp_hit & BTB_ON);
      exp_next = (exp_hit & BTB_ON) ? exp_tgt : x + 64'd4;
      tick();
      chk64("probe_next", pc_IF, exp_next);
      $display("[TB] probe pc=%h pred=%b next=%h", x, exp_hit & BTB_ON, exp_next);
      idle();
   endtask

   initial begin
      resetl = 1'b0;
      idle();
      repeat (2) @(negedge clk);

      // Reset held: redirect inputs must not reach flush.
      mem_branch_valid = 1'b1;
      mispredict_MEM   = 1'b1;
      #1;
      chk1("rst_flush", flush, 1'b0);
      chk1("rst_pred", predicted_taken_IF, 1'b0);
      chk64("rst_pc", pc_IF, 64'h1000);
      idle();
      resetl = 1'b1;
      #1;
      chk64("rel_pc0", pc_IF, 64'h1000);
      tick();
      chk64("rel_pc1", pc_IF, 64'h1004);
      tick();
      chk64("rel_pc2", pc_IF, 64'h1008);
      chk1("rel_flush", flush, 1'b0);
      $display("[TB] reset sequence 1000/1004/1008");

      // Allocate 1008->2000 while fetching 1008: lookup sees the old BTB.
      mem_branch_valid  = 1'b1;
      branch_taken_MEM  = 1'b1;
      pc_MEM            = 64'h1008;
      branch_target_MEM = 64'h2000;
      branch_predict    = 1'b1;
      #1;
      chk1("nobypass_pred", predicted_taken_IF, 1'b0);
      chk1("alloc_flush", flush, 1'b0);
      tick();
      idle();
      chk64("nobypass_pc", pc_IF, 64'h100C);
      $display("[TB] alloc pc_MEM=1008 target=2000");

      // Back to 1008 via a not-taken redirect from 1004.
      mem_branch_valid = 1'b1;
      mispredict_MEM   = 1'b1;
      pc_MEM           = 64'h1004;
      #1;
      chk1("back_flush", flush, 1'b1);
      tick();
      idle();
      chk64("back_pc", pc_IF, 64'h1008);

      // Stall suppresses the prediction and holds the PC.
      stall_IF       = 1'b1;
      branch_predict = 1'b1;
      #1;
      chk1("stall_pred", predicted_taken_IF, 1'b0);
      tick();
      chk64("stall_hold", pc_IF, 64'h1008);

      stall_IF = 1'b0;
      #1;
      chk1("hit_pred", predicted_taken_IF, BTB_ON);
      tick();
      chk64("hit_next", pc_IF, BTB_ON ? 64'h2000 : 64'h100C);
      idle();
      $display("[TB] predict at 1008");

      // Mispredict while stalled: flush for exactly one cycle, go to 100C.
      stall_IF         = 1'b1;
      mem_branch_valid = 1'b1;
      mispredict_MEM   = 1'b1;
      pc_MEM           = 64'h1008;
      #1;
      chk1("mis_flush", flush, 1'b1);
      chk1("mis_pred", predicted_taken_IF, 1'b0);
      tick();
      chk64("mis_pc", pc_IF, 64'h100C);
      mem_branch_valid = 1'b0;
      mispredict_MEM   = 1'b0;
      #1;
      chk1("mis_flush_drop", flush, 1'b0);
      tick();
      chk64("mis_hold", pc_IF, 64'h100C);
      $display("[TB] mispredict pc_MEM=1008 stalled -> 100C");

      // Four more taken branches while stalled (updates ignore the stall):
      // the fifth allocation overall evicts 1008.
      for (int i = 0; i < 4; i++) begin
         mem_branch_valid  = 1'b1;
         branch_taken_MEM  = 1'b1;
         pc_MEM            = 64'h3000 + 64'(i) * 64'h100;
         branch_target_MEM = 64'h4000 + 64'(i) * 64'h100;
         tick();
         $display("[TB] alloc pc_MEM=%h target=%h", pc_MEM, branch_target_MEM);
      end
      chk64("alloc_hold", pc_IF, 64'h100C);
      idle();

      probe(64'h1008, 1'b0, 64'h0);
      probe(64'h3000, 1'b1, 64'h4000);
      probe(64'h3100, 1'b1, 64'h4100);
      probe(64'h3200, 1'b1, 64'h4200);
      probe(64'h3300, 1'b1, 64'h4300);

      // Taken branch already present: target refreshed, nothing evicted.
      mem_branch_valid  = 1'b1;
      branch_taken_MEM  = 1'b1;
      pc_MEM            = 64'h3100;
      branch_target_MEM = 64'h5100;
      tick();
      idle();
      probe(64'h3100, 1'b1, 64'h5100);
      probe(64'h3000, 1'b1, 64'h4000);

      // Not-taken resolution never allocates.
      mem_branch_valid = 1'b1;
      pc_MEM           = 64'h3600;
      tick();
      idle();
      probe(64'h3600, 1'b0, 64'h0);

      // Sequential wrap at the top of the address space.
      probe(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0);

      // Not-taken redirect from the last word wraps too.
      mem_branch_valid = 1'b1;
      mispredict_MEM   = 1'b1;
      pc_MEM           = 64'hFFFF_FFFF_FFFF_FFFC;
      tick();
      idle();
      chk64("redir_wrap", pc_IF, 64'h0);

      // Taken redirect goes to the MEM target.
      mem_branch_valid  = 1'b1;
      mispredict_MEM    = 1'b1;
      branch_taken_MEM  = 1'b1;
      pc_MEM            = 64'h7000;
      branch_target_MEM = 64'h8000;
      tick();
      idle();
      chk64("redir_taken", pc_IF, 64'h8000);
      $display("[TB] taken redirect 7000 -> 8000");

      // Reset mid-cycle with a redirect pending: PC reloads at once.
      mem_branch_valid  = 1'b1;
      mispredict_MEM    = 1'b1;
      branch_taken_MEM  = 1'b1;
      pc_MEM            = 64'h7100;
      branch_target_MEM = 64'h9000;
      #2;
      resetl = 1'b0;
      #1;
      chk64("arst_pc", pc_IF, 64'h1000);
      chk1("arst_flush", flush, 1'b0);
      @(negedge clk);
      idle();
      resetl = 1'b1;
      #1;
      chk64("arst_rel_pc", pc_IF, 64'h1000);
      tick();
      chk64("arst_rel_pc1", pc_IF, 64'h1004);
      $display("[TB] mid-run reset");

      // BTB contents are gone after reset.
      probe(64'h7000, 1'b0, 64'h0);
      probe(64'h3300, 1'b0, 64'h0);

      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, the PC value loaded on reset.
REQ-002 SHALL have parameter BTB_ENTRIES, default 4, the number of fully-associative BTB entries (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetl  input  1  asynchronous active-low reset.
REQ-005 SHALL have port stall_IF  input  1  holds the PC when high.
REQ-006 SHALL have port branch_predict  input  1  taken/not-taken prediction from the branch predictor for pc_IF.
REQ-007 SHALL have port mem_branch_valid  input  1  a branch resolves in MEM this cycle.
REQ-008 SHALL have port pc_MEM  input  64  PC of the resolving branch.
REQ-009 SHALL have port branch_taken_MEM  input  1  actual branch outcome.
REQ-010 SHALL have port branch_target_MEM  input  64  actual taken target.
REQ-011 SHALL have port mispredict_MEM  input  1  the prediction for the MEM branch was wrong; qualified by mem_branch_valid.
REQ-012 SHALL have port pc_IF  output  64  current fetch PC, registered.
REQ-013 SHALL have port predicted_taken_IF  output  1  fetch redirected this cycle by a taken prediction.
REQ-014 SHALL have port flush  output  1  squash IF/ID, ID/EX and EX/MEM contents.

Function
REQ-015 SHALL look up pc_IF combinationally against all valid BTB tags (pc bits 63:2); hit = exactly one matching valid entry.
REQ-016 SHALL drive predicted_taken_IF = hit & branch_predict & ~stall_IF & ~redirect, where redirect = mem_branch_valid & mispredict_MEM.
REQ-017 SHALL select the next PC with priority: redirect, then stall_IF (hold), then predicted_taken_IF (hit target), then pc_IF + 4.
REQ-018 SHALL compute the redirect PC as branch_target_MEM if branch_taken_MEM, else pc_MEM + 4.
REQ-019 SHALL assert flush combinationally for exactly the cycle redirect is high, independent of stall_IF.
REQ-020 SHALL compute pc + 4 modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC + 4 = 0).
REQ-021 SHALL, on mem_branch_valid & branch_taken_MEM with pc_MEM hitting, overwrite that entry's target with branch_target_MEM.
REQ-022 SHALL, on mem_branch_valid & branch_taken_MEM with pc_MEM missing, allocate the entry at the replacement pointer (valid=1, tag, target), then increment the pointer modulo BTB_ENTRIES (FIFO replacement).
REQ-023 SHALL NOT allocate or modify entries for not-taken branches.
REQ-024 SHALL give the lookup pre-update BTB contents when update and lookup target the same PC in one cycle (no bypass).
REQ-025 SHALL perform BTB updates regardless of stall_IF.

Reset
REQ-026 SHALL, while resetl is low, asynchronously set pc_IF = RESET_PC, clear all valid bits, and set the replacement pointer to 0; flush and predicted_taken_IF are then 0.
REQ-027 SHALL, on reset assertion mid-operation, discard any pending update or redirect; the first post-reset fetch is RESET_PC.

Configuration
REQ-028 SHALL, with FETCH_BTB_EN defined, implement the BTB per REQ-015..REQ-025.
REQ-029 SHALL, without FETCH_BTB_EN, contain no BTB storage, tie hit to 0 (predicted_taken_IF = 0, no predicted redirect), and keep redirect/flush behaviour unchanged.

Structure
REQ-030 SHALL take from shared package fetch_pkg: PC_WIDTH = 64, INSTR_BYTES = 4, and the btb_entry_t struct (valid, tag[61:0], target[63:0]).
REQ-031 SHALL place BTB storage, tag compare and FIFO pointer in one sub-module btb_cam; next-PC mux and flush stay in fetch_pc_unit.

Verification
REQ-032 SHALL cover reset: RESET_PC = 64'h1000, release resetl -> pc_IF 1000, 1004, 1008 on successive edges; flush = 0.
REQ-033 SHALL cover allocation and prediction: resolve taken branch pc_MEM = 1008, target 2000; later pc_IF = 1008 with branch_predict = 1 -> predicted_taken_IF = 1, next pc_IF = 2000.
REQ-034 SHALL cover misprediction: redirect with branch_taken_MEM = 0, pc_MEM = 1008 while stall_IF = 1 -> flush = 1 for one cycle, next pc_IF = 100C.
REQ-035 SHALL cover FIFO wrap: five distinct taken branches with BTB_ENTRIES = 4 -> first-allocated PC misses, the other four hit.
REQ-036 SHALL cover wrap-around: pc_IF = 64'hFFFF_FFFF_FFFF_FFFC with no hit -> next pc_IF = 0.
REQ-037 SHALL cover the build without FETCH_BTB_EN: the REQ-033 stimulus yields predicted_taken_IF = 0, pc_IF = 100C.
